core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core: fetches each instruction, presents it to decode,

---
 rtl/core_sequencer.sv | 111 +++++++++++
 tb/tb_core_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback and owns the PC, instruction latch and retire counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  input  logic        dec_wrt_en,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_illegal,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        wrt_en,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, ins_q, instret_q;
  logic        wb_fault, wb_commit;

  // A taken branch/jump to a non-word-aligned target halts the core instead of retiring.
  assign wb_fault  = br_taken && (br_target[1:0] != 2'b00);
  assign wb_commit = (state == S_WB) && !wb_fault;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    wrt_en     = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    unique case (state)
      S_RST:    state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = S_DECODE;
      end
      S_DECODE: state_next = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC:   state_next = (dec_load || dec_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_store;
        if (dmem_ack) state_next = S_WB;
      end
      S_WB: begin
        if (wb_fault) begin
          state_next = S_TRAP;
        end else begin
          wrt_en     = dec_wrt_en;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_TRAP:   trap = 1'b1;
      default:  state_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ins_q     <= NOP;
      instret_q <= INSTRET_INIT;
    end else begin
      if (state == S_FETCH && imem_ack) ins_q <= imem_rdata;
      if (wb_commit) begin
        pc_q      <= br_taken ? br_target : pc_q + 32'd4;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: scoreboarded fetch stream plus per-scenario checks.
// A second instance with the retire counter starting at 2^32-1 runs in lockstep to cover wrap-around.
module tb_core_sequencer;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] W_ADDI0 = 32'h0010_0093;
  localparam logic [31:0] W_ADDI1 = 32'h0020_0113;
  localparam logic [31:0] W_ADDI2 = 32'h0030_0193;
  localparam logic [31:0] W_LW    = 32'h0000_A203;
  localparam logic [31:0] W_BEQ   = 32'h0220_8063;
  localparam logic [31:0] W_JAL   = 32'h0100_00EF;
  localparam logic [31:0] W_JALR  = 32'h0020_80E7;
  localparam logic [31:0] W_SW    = 32'h0040_A023;
  localparam logic [31:0] W_ILL   = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        imem_ack, dmem_ack;
  logic [31:0] imem_rdata;
  logic        dec_wrt_en, dec_load, dec_store, dec_illegal, br_taken;
  logic [31:0] br_target;
  logic        imem_req, dmem_req, dmem_we, wrt_en, retire, trap;
  logic [31:0] imem_addr, ins, pc, instret;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_wrt_en, w_retire, w_trap;
  logic [31:0] w_imem_addr, w_ins, w_pc, w_instret;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;
  fetch_t exp_q[$];

  core_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .dec_wrt_en(dec_wrt_en), .dec_load(dec_load), .dec_store(dec_store),
    .dec_illegal(dec_illegal), .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .wrt_en(wrt_en), .pc(pc), .retire(retire), .instret(instret), .trap(trap)
  );

  core_sequencer #(.INSTRET_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(w_ins), .dec_wrt_en(dec_wrt_en), .dec_load(dec_load), .dec_store(dec_store),
    .dec_illegal(dec_illegal), .br_taken(br_taken), .br_target(br_target),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
    .wrt_en(w_wrt_en), .pc(w_pc), .retire(w_retire), .instret(w_instret), .trap(w_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    dmem_ack    = 1'b0;
    dec_wrt_en  = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_illegal = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
  endtask

  // Ends at the negedge where rst is released; the design sits in RST for the following cycle.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a FETCH negedge: supplies the next scoreboard word with a zero-wait ack and
  // returns at the DECODE negedge with the sampled fetch address and latched instruction.
  task automatic issue(output logic [31:0] got_addr, output logic [31:0] got_ins, output fetch_t e);
    if (exp_q.size() == 0) begin
      e.addr = 32'hFFFF_FFFF;
      e.word = 32'h0BAD_0BAD;
    end else begin
      e = exp_q.pop_front();
    end
    got_addr   = imem_addr;
    imem_rdata = e.word;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    got_ins    = ins;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({pc, ins, instret} !== {32'h0, NOP, 32'h0}) begin
      n_err++;
      $display("FAIL reset_regs: got pc/ins/instret %h expected %h", {pc, ins, instret}, {32'h0, NOP, 32'h0});
    end
    n_vec++;
    if ({imem_req, dmem_req, dmem_we, wrt_en, retire, trap} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 000000", {imem_req, dmem_req, dmem_we, wrt_en, retire, trap});
    end
    n_vec++;
    if (w_instret !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_wrap_preload: got %h expected ffffffff", w_instret);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_state_req: got %b expected 0", imem_req);
    end
    @(negedge clk);
    n_vec++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL rst_to_fetch: got req/addr %b/%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  // imem_ack tied high, three ADDIs: fetch at 0,4,8 and a retire every fourth cycle.
  task automatic test_alu();
    fetch_t      e;
    logic [31:0] last_word;
    last_word = NOP;
    exp_q.push_back('{32'h0, W_ADDI0});
    exp_q.push_back('{32'h4, W_ADDI1});
    exp_q.push_back('{32'h8, W_ADDI2});
    dec_wrt_en = 1'b1;
    imem_ack   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (imem_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          e.addr = 32'hFFFF_FFFF;
          e.word = 32'h0BAD_0BAD;
        end else begin
          e = exp_q.pop_front();
        end
        n_vec++;
        if (imem_addr !== e.addr) begin
          n_err++;
          $display("FAIL alu_fetch_addr c%0d: got %h expected %h", c, imem_addr, e.addr);
        end
        imem_rdata = e.word;
        last_word  = e.word;
      end else begin
        n_vec++;
        if (ins !== last_word) begin
          n_err++;
          $display("FAIL alu_ins c%0d: got %h expected %h", c, ins, last_word);
        end
      end
      n_vec++;
      if ({retire, wrt_en} !== {2{c % 4 == 0}}) begin
        n_err++;
        $display("FAIL alu_retire c%0d: got retire/wrt_en %b%b expected %0d", c, retire, wrt_en, (c % 4 == 0));
      end
      // The lockstep instance started at 2^32-1, so its first retire wraps it to zero.
      if (c == 5) begin
        n_vec++;
        if ({instret, w_instret} !== {32'd1, 32'd0}) begin
          n_err++;
          $display("FAIL instret_wrap: got %h/%h expected 00000001/00000000", instret, w_instret);
        end
      end
      if (c == 12) imem_ack = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({instret, pc, imem_req} !== {32'd3, 32'hC, 1'b1}) begin
      n_err++;
      $display("FAIL alu_final: got instret/pc/req %h/%h/%b expected 00000003/0000000c/1", instret, pc, imem_req);
    end
  endtask

  // Load at pc=0xC with dmem_ack withheld for three cycles.
  task automatic test_load();
    fetch_t      e;
    logic [31:0] a, i;
    int          req_cycles;
    bit          ok;
    exp_q.push_back('{32'hC, W_LW});
    dec_load   = 1'b1;
    dec_wrt_en = 1'b1;
    issue(a, i, e);
    n_vec++;
    if ({a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL load_fetch: got addr/ins %h/%h expected %h/%h", a, i, e.addr, e.word);
    end
    @(negedge clk);
    n_vec++;
    if (dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL load_exec_req: got %b expected 0", dmem_req);
    end
    req_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1) break;
      req_cycles++;
      n_vec++;
      if ({dmem_we, wrt_en, retire} !== 3'b000) begin
        n_err++;
        $display("FAIL load_mem_wait: got we/wrt_en/retire %b expected 000", {dmem_we, wrt_en, retire});
      end
      dmem_ack = (req_cycles == 4);
    end
    dmem_ack = 1'b0;
    dec_load = 1'b0;
    n_vec++;
    if (req_cycles !== 4) begin
      n_err++;
      $display("FAIL load_req_cycles: got %0d expected 4", req_cycles);
    end
    n_vec++;
    if ({wrt_en, retire} !== 2'b11) begin
      n_err++;
      $display("FAIL load_wb: got wrt_en/retire %b expected 11", {wrt_en, retire});
    end
    wait_fetch(ok);
    n_vec++;
    if (!ok || {imem_addr, instret} !== {32'h10, 32'd4}) begin
      n_err++;
      $display("FAIL load_next: got ok/addr/instret %0d/%h/%h expected 1/00000010/00000004", ok, imem_addr, instret);
    end
  endtask

  // Taken branch 0x10 -> 0x40, then a back-to-back jump 0x40 -> 0x10.
  task automatic test_branch();
    fetch_t      e;
    logic [31:0] a, i;
    exp_q.push_back('{32'h10, W_BEQ});
    exp_q.push_back('{32'h40, W_JAL});
    dec_wrt_en = 1'b0;
    br_taken   = 1'b1;
    br_target  = 32'h40;
    issue(a, i, e);
    n_vec++;
    if ({a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL br_fetch: got addr/ins %h/%h expected %h/%h", a, i, e.addr, e.word);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({retire, wrt_en} !== 2'b10) begin
      n_err++;
      $display("FAIL br_wb: got retire/wrt_en %b expected 10", {retire, wrt_en});
    end
    @(negedge clk);
    dec_wrt_en = 1'b1;
    br_target  = 32'h10;
    issue(a, i, e);
    n_vec++;
    if ({a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL br_target_fetch: got addr/ins %h/%h expected %h/%h", a, i, e.addr, e.word);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({retire, wrt_en} !== 2'b11) begin
      n_err++;
      $display("FAIL jal_wb: got retire/wrt_en %b expected 11", {retire, wrt_en});
    end
    @(negedge clk);
    n_vec++;
    if ({imem_req, imem_addr, instret} !== {1'b1, 32'h10, 32'd6}) begin
      n_err++;
      $display("FAIL jal_next: got req/addr/instret %b/%h/%h expected 1/00000010/00000006", imem_req, imem_addr, instret);
    end
  endtask

  // Jump from 0x10 to misaligned 0x42: no write, no retire, pc held, core halts.
  task automatic test_misaligned();
    fetch_t      e;
    logic [31:0] a, i;
    exp_q.push_back('{32'h10, W_JALR});
    dec_wrt_en = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h42;
    issue(a, i, e);
    n_vec++;
    if ({a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL mis_fetch: got addr/ins %h/%h expected %h/%h", a, i, e.addr, e.word);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({retire, wrt_en, trap} !== 3'b000) begin
      n_err++;
      $display("FAIL mis_wb: got retire/wrt_en/trap %b expected 000", {retire, wrt_en, trap});
    end
    @(negedge clk);
    n_vec++;
    if ({trap, imem_req, pc, instret} !== {1'b1, 1'b0, 32'h10, 32'd6}) begin
      n_err++;
      $display("FAIL mis_trap: got trap/req/pc/instret %b/%b/%h/%h expected 1/0/00000010/00000006", trap, imem_req, pc, instret);
    end
  endtask

  task automatic test_illegal();
    fetch_t      e;
    logic [31:0] a, i;
    bit          ok;
    do_reset();
    wait_fetch(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL ill_wait_fetch: got timeout expected FETCH");
    end
    exp_q.push_back('{32'h0, W_ILL});
    dec_illegal = 1'b1;
    issue(a, i, e);
    n_vec++;
    if ({a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL ill_fetch: got addr/ins %h/%h expected %h/%h", a, i, e.addr, e.word);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++;
      if ({trap, imem_req, dmem_req, retire, wrt_en, pc, ins, instret} !== {5'b10000, 32'h0, W_ILL, 32'h0}) begin
        n_err++;
        $display("FAIL ill_halt k%0d: got flags %b pc %h ins %h instret %h", k,
                 {trap, imem_req, dmem_req, retire, wrt_en}, pc, ins, instret);
      end
      imem_ack   = ~imem_ack;
      imem_rdata = $urandom;
    end
    imem_ack    = 1'b0;
    dec_illegal = 1'b0;
  endtask

  // Acks arriving in DECODE/EXEC/WB must not disturb ins or the state sequence.
  task automatic test_spurious();
    fetch_t      e;
    logic [31:0] a, i;
    bit          ok;
    do_reset();
    wait_fetch(ok);
    exp_q.push_back('{32'h0, W_ADDI1});
    dec_wrt_en = 1'b1;
    issue(a, i, e);
    n_vec++;
    if (!ok || {a, i} !== {e.addr, e.word}) begin
      n_err++;
      $display("FAIL sp_fetch: got ok/addr/ins %0d/%h/%h expected 1/%h/%h", ok, a, i, e.addr, e.word);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    dmem_ack   = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ins, imem_req, dmem_req, retire} !== {W_ADDI1, 3'b000}) begin
      n_err++;
      $display("FAIL sp_exec: got ins %h req %b%b retire %b", ins, imem_req, dmem_req, retire);
    end
    @(negedge clk);
    n_vec++;
    if ({ins, retire} !== {W_ADDI1, 1'b1}) begin
      n_err++;
      $display("FAIL sp_wb: got ins/retire %h/%b expected %h/1", ins, retire, W_ADDI1);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ins, imem_addr, instret} !== {W_ADDI1, 32'h4, 32'd1}) begin
      n_err++;
      $display("FAIL sp_next: got ins/addr/instret %h/%h/%h expected %h/00000004/00000001", ins, imem_addr, instret, W_ADDI1);
    end
  endtask

  // Store parked in MEM waiting for dmem_ack when reset hits.
  task automatic test_reset_mid_mem();
    fetch_t      e;
    logic [31:0] a, i;
    exp_q.push_back('{32'h4, W_SW});
    dec_store  = 1'b1;
    dec_wrt_en = 1'b0;
    issue(a, i, e);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a, i, dmem_req, dmem_we} !== {e.addr, e.word, 2'b11}) begin
      n_err++;
      $display("FAIL rm_store_mem: got addr/ins %h/%h req/we %b%b", a, i, dmem_req, dmem_we);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({imem_req, dmem_req, dmem_we, wrt_en, retire, trap, pc, ins, instret} !== {6'b0, 32'h0, NOP, 32'h0}) begin
      n_err++;
      $display("FAIL rm_abort: got flags %b pc %h ins %h instret %h", {imem_req, dmem_req, dmem_we, wrt_en, retire, trap}, pc, ins, instret);
    end
    @(negedge clk);
    rst       = 1'b1;
    dec_store = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rm_rst_state: got req %b expected 0", imem_req);
    end
    @(negedge clk);
    n_vec++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL rm_refetch: got req/addr %b/%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_misaligned();
    test_illegal();
    test_spurious();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
